// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches, buffers in-order responses.
// Optional FETCH_MISALIGN_CHECK_EN: a misaligned redirect sets a sticky error and halts fetching.
module instr_fetch #(
  parameter int             N          = 32,
  parameter logic [N-1:0]   RESET_PC   = '0,
  parameter int             FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic [N-1:0] mem_req_addr,
  input  logic         mem_rsp_valid,
  input  logic [N-1:0] mem_rsp_data,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [N-1:0] instr,
  output logic [N-1:0] instr_pc,
  output logic         misalign_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]  DEPTH_LIMIT = (CW+1)'(FIFO_DEPTH);
  localparam logic [N-1:0] ALIGN_MASK  = ~N'(3);

  logic [N-1:0]  pc_reg;
  logic [CW-1:0] outstanding_reg, discard_reg, fifo_count_reg;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, tag_wr_ptr_reg, tag_rd_ptr_reg;
  logic          run_reg;
  logic          halted;

  logic [N-1:0] data_mem [FIFO_DEPTH];
  logic [N-1:0] pc_mem   [FIFO_DEPTH];
  logic [N-1:0] tag_mem  [FIFO_DEPTH];

  logic [CW:0] in_use;
  logic        req_fire, rsp_drop, push, pop;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_reg <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      misalign_reg <= 1'b1;
    end
  end

  assign halted       = misalign_reg;
  assign misalign_err = misalign_reg;
`else
  assign halted       = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Credits cover in-flight requests plus buffered entries, so every response has a slot.
  assign in_use        = {1'b0, outstanding_reg} + {1'b0, fifo_count_reg};
  assign mem_req_valid = run_reg && !redirect && !halted && (in_use < DEPTH_LIMIT);
  assign mem_req_addr  = pc_reg;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // A response landing in a redirect cycle belongs to the old stream and is dropped.
  assign rsp_drop = mem_rsp_valid && (redirect || (discard_reg != '0));
  assign push     = mem_rsp_valid && !rsp_drop;

  assign instr_valid = (fifo_count_reg != '0);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign instr       = instr_valid ? data_mem[rd_ptr_reg] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr_reg]   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg          <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      fifo_count_reg  <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      tag_wr_ptr_reg  <= '0;
      tag_rd_ptr_reg  <= '0;
      run_reg         <= 1'b0;
    end else begin
      run_reg         <= 1'b1;
      outstanding_reg <= outstanding_reg + CW'(req_fire) - CW'(mem_rsp_valid);
      if (req_fire)      tag_wr_ptr_reg <= tag_wr_ptr_reg + AW'(1);
      if (mem_rsp_valid) tag_rd_ptr_reg <= tag_rd_ptr_reg + AW'(1);
      if (redirect) begin
        pc_reg         <= redirect_pc & ALIGN_MASK;
        discard_reg    <= outstanding_reg - CW'(mem_rsp_valid);
        fifo_count_reg <= '0;
        wr_ptr_reg     <= '0;
        rd_ptr_reg     <= '0;
      end else begin
        if (req_fire) pc_reg      <= pc_reg + N'(4);
        if (rsp_drop) discard_reg <= discard_reg - CW'(1);
        if (push)     wr_ptr_reg  <= wr_ptr_reg + AW'(1);
        if (pop)      rd_ptr_reg  <= rd_ptr_reg + AW'(1);
        fifo_count_reg <= fifo_count_reg + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage entries carry no reset; validity is tracked by the counters above.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (req_fire && (tag_wr_ptr_reg == AW'(gi))) begin
        tag_mem[gi] <= pc_reg;
      end
      if (push && (wr_ptr_reg == AW'(gi))) begin
        data_mem[gi] <= mem_rsp_data;
        pc_mem[gi]   <= tag_mem[tag_rd_ptr_reg];
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a simple in-order instruction memory model.
module tb_instr_fetch;

  localparam logic [31:0] KEY = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        misalign_err;

  bit          rsp_en;
  logic [31:0] mem_q[$];
  logic [31:0] req_log[$];
  logic [31:0] got_pc[$];
  int          checks = 0;
  int          errors = 0;

  instr_fetch #(.N(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // One clock cycle: sample handshakes mid-cycle, then drive the next response after the edge.
  task automatic step();
    @(negedge clk);
    if (mem_rsp_valid) void'(mem_q.pop_front());
    if (mem_req_valid && mem_req_ready) begin
      mem_q.push_back(mem_req_addr);
      req_log.push_back(mem_req_addr);
    end
    if (instr_valid && instr_ready) begin
      got_pc.push_back(instr_pc);
      $display("pop pc=%h instr=%h", instr_pc, instr);
      checks++;
      if (instr !== (instr_pc ^ KEY)) begin
        errors++;
        $display("FAIL instr_data: got %h expected %h", instr, instr_pc ^ KEY);
      end
    end
    @(posedge clk);
    #1;
    mem_rsp_valid = rsp_en && (mem_q.size() > 0);
    mem_rsp_data  = mem_rsp_valid ? (mem_q[0] ^ KEY) : 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = 32'h0;
    mem_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_log.delete();
    got_pc.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", mem_req_valid); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", misalign_err); end
    checks++; if (mem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_req_addr); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 0", instr_pc); end
    rst_n = 1'b1;
    step();
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin errors++; $display("FAIL first_req: got valid=%b addr=%h expected valid=1 addr=0", mem_req_valid, mem_req_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset();
    rsp_en = 1'b1; mem_req_ready = 1'b1; instr_ready = 1'b1;
    repeat (12) step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (req_log.size() <= i || req_log[i] !== exp_pc[i]) begin
        errors++; $display("FAIL stream_addr[%0d]: got %h expected %h", i, (req_log.size() > i) ? req_log[i] : 32'hx, exp_pc[i]);
      end
      checks++;
      if (got_pc.size() <= i || got_pc[i] !== exp_pc[i]) begin
        errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, (got_pc.size() > i) ? got_pc[i] : 32'hx, exp_pc[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc [3];
    exp_pc = '{32'h0, 32'h4, 32'h8};
    do_reset();
    rsp_en = 1'b1; mem_req_ready = 1'b1; instr_ready = 1'b0;
    repeat (10) step();
    checks++; if (req_log.size() != 2) begin errors++; $display("FAIL stall_req_count: got %0d expected 2", req_log.size()); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid: got %b expected 0", mem_req_valid); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_instr_valid: got %b expected 1", instr_valid); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL stall_instr_pc: got %h expected 0", instr_pc); end
    checks++; if (instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_instr: got %h expected deadbeef", instr); end
    instr_ready = 1'b1;
    repeat (8) step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_pc.size() <= i || got_pc[i] !== exp_pc[i]) begin
        errors++; $display("FAIL stall_release_pc[%0d]: got %h expected %h", i, (got_pc.size() > i) ? got_pc[i] : 32'hx, exp_pc[i]);
      end
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    rsp_en = 1'b0; mem_req_ready = 1'b1; instr_ready = 1'b1;
    repeat (4) step();
    checks++; if (req_log.size() != 2) begin errors++; $display("FAIL inflight_count: got %0d expected 2", req_log.size()); end
    redirect = 1'b1; redirect_pc = 32'h0000_0100; rsp_en = 1'b1;
    step();
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL inflight_flush: got instr_valid=%b expected 0", instr_valid); end
    repeat (10) step();
    checks++; if (got_pc.size() < 1 || got_pc[0] !== 32'h100) begin errors++; $display("FAIL inflight_first_pc: got %h expected 00000100", (got_pc.size() > 0) ? got_pc[0] : 32'hx); end
    checks++; if (got_pc.size() < 2 || got_pc[1] !== 32'h104) begin errors++; $display("FAIL inflight_second_pc: got %h expected 00000104", (got_pc.size() > 1) ? got_pc[1] : 32'hx); end
  endtask

  task automatic test_redirect_collide();
    bit found = 1'b0;
    do_reset();
    rsp_en = 1'b1; mem_req_ready = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (instr_valid && mem_rsp_valid) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL collide_setup: got no response+pop cycle expected one within 20 cycles"); end
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    #1;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL collide_req_valid: got %b expected 0", mem_req_valid); end
    step();
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL collide_flush: got instr_valid=%b expected 0", instr_valid); end
    got_pc.delete();
    repeat (8) step();
    checks++; if (got_pc.size() < 1 || got_pc[0] !== 32'h200) begin errors++; $display("FAIL collide_first_pc: got %h expected 00000200", (got_pc.size() > 0) ? got_pc[0] : 32'hx); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    bit ready_seen = 1'b0;
    exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    for (int i = 0; i < 10 && !ready_seen; i++) begin
      step();
      if (mem_req_valid) ready_seen = 1'b1;
    end
    checks++; if (!ready_seen) begin errors++; $display("FAIL wrap_setup: got no request expected one within 10 cycles"); end
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    #1;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL wrap_redirect_req_valid: got %b expected 0", mem_req_valid); end
    step();
    redirect = 1'b0;
    req_log.delete();
    got_pc.delete();
    repeat (10) step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req_log.size() <= i || req_log[i] !== exp_pc[i]) begin
        errors++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, (req_log.size() > i) ? req_log[i] : 32'hx, exp_pc[i]);
      end
      checks++;
      if (got_pc.size() <= i || got_pc[i] !== exp_pc[i]) begin
        errors++; $display("FAIL wrap_pc[%0d]: got %h expected %h", i, (got_pc.size() > i) ? got_pc[i] : 32'hx, exp_pc[i]);
      end
    end
  endtask

  task automatic test_misalign();
    do_reset();
    rsp_en = 1'b1; mem_req_ready = 1'b1; instr_ready = 1'b1;
    repeat (4) step();
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    step();
    redirect = 1'b0;
    req_log.delete();
    got_pc.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL misalign_set: got %b expected 1", misalign_err); end
    repeat (6) step();
    checks++; if (req_log.size() != 0) begin errors++; $display("FAIL misalign_halt: got %0d requests expected 0", req_log.size()); end
    checks++; if (mem_req_valid !== 1'b0 || misalign_err !== 1'b1) begin errors++; $display("FAIL misalign_sticky: got valid=%b err=%b expected valid=0 err=1", mem_req_valid, misalign_err); end
    do_reset();
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL misalign_clear: got %b expected 0", misalign_err); end
    step();
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL misalign_resume: got %b expected 1", mem_req_valid); end
`else
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL misalign_tied: got %b expected 0", misalign_err); end
    repeat (8) step();
    checks++; if (req_log.size() < 1 || req_log[0] !== 32'h100) begin errors++; $display("FAIL misalign_addr: got %h expected 00000100", (req_log.size() > 0) ? req_log[0] : 32'hx); end
    checks++; if (got_pc.size() < 1 || got_pc[0] !== 32'h100) begin errors++; $display("FAIL misalign_pc: got %h expected 00000100", (got_pc.size() > 0) ? got_pc[0] : 32'hx); end
`endif
  endtask

  initial begin
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0; rsp_en = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_collide();
    test_wrap();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
